adam_mem_pwr_seq: RTL and testbench

Power sequencer for the high-speed-domain memory banks. It accepts one power-on or power-off command at a time for a selected bank. It drives that bank's `mem_rst` and pause request in the required order and waits for the bank's pause acknowledge. It sits between the SoC power-management logic and the per-bank `hsdom_mem_rst` / `hsdom_mem_pause` signals, so software can gate individual RAM banks without glitching in-flight AXI-Lite traffic.

---
 rtl/adam_mem_pwr_seq.sv | 191 +++++++++++++++++++
 tb/tb_adam_mem_pwr_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/adam_mem_pwr_seq.sv
// Purpose  : per-bank power sequencer for the high-speed-domain RAM banks; runs one
//            power-on / power-off command at a time and orders mem_rst / pause handshakes.
// Latency  : power-on >= RST_CYCLES+3 cycles, power-off >= 3 cycles, no-op/illegal 1 cycle to rsp_valid.
// Backpress: cmd_ready is high only while idle; a new command is taken the cycle after rsp_valid.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake; cmd_bank selects the bank, cmd_on picks on(1)/off(0)
//   rsp_valid, rsp_err       one-cycle completion pulse, err qualifies it
//   mem_rst, mem_pause_req   per-bank reset and pause request outputs
//   mem_pause_ack            per-bank pause acknowledge input
//   bank_on                  per-bank powered-and-running status
//
// Build option: define ADAM_MEM_PWR_SEQ_TIMEOUT_EN to bound the pause-ack waits by
// ACK_TIMEOUT cycles; on expiry the bank is forced off and the response carries rsp_err.
module adam_mem_pwr_seq #(
    parameter int NO_MEMS     = 3,
    parameter int RST_CYCLES  = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     cmd_valid,
    output logic                                     cmd_ready,
    input  logic [((NO_MEMS > 1) ? $clog2(NO_MEMS) : 1)-1:0] cmd_bank,
    input  logic                                     cmd_on,
    output logic                                     rsp_valid,
    output logic                                     rsp_err,
    output logic [NO_MEMS-1:0]                       mem_rst,
    output logic [NO_MEMS-1:0]                       mem_pause_req,
    input  logic [NO_MEMS-1:0]                       mem_pause_ack,
    output logic [NO_MEMS-1:0]                       bank_on
);

    localparam int BW      = (NO_MEMS > 1) ? $clog2(NO_MEMS) : 1;
    localparam int CNT_MAX = (RST_CYCLES > ACK_TIMEOUT) ? RST_CYCLES : ACK_TIMEOUT;
    localparam int CNT_RAW = $clog2(CNT_MAX + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : CNT_RAW;

    localparam logic [CNT_W-1:0]   CNT_RST_LAST = CNT_W'(RST_CYCLES - 1);
`ifdef ADAM_MEM_PWR_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0]   CNT_TMO      = CNT_W'(ACK_TIMEOUT);
`endif
    localparam logic [NO_MEMS-1:0] ONE          = NO_MEMS'(1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RST_HOLD = 3'd1;
    localparam logic [2:0] RST_REL  = 3'd2;
    localparam logic [2:0] RESUME   = 3'd3;
    localparam logic [2:0] PAUSE    = 3'd4;
    localparam logic [2:0] RST_SET  = 3'd5;
    localparam logic [2:0] RESP     = 3'd6;

    logic [2:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [BW-1:0]      bank_q;

    logic [NO_MEMS-1:0] sel_q;     // one-hot of the latched target bank
    logic [NO_MEMS-1:0] sel_in;    // one-hot of the incoming command's bank
    logic               cmd_legal;
    logic               cur_on;
    logic               ack_hit;

    // All per-bank updates go through one-hot masks so banks other than the
    // target can never be touched, and out-of-range indices select nothing.
    assign sel_q     = ONE << bank_q;
    assign sel_in    = ONE << cmd_bank;
    assign cmd_legal = (32'(cmd_bank) < 32'(NO_MEMS));
    assign cur_on    = |(bank_on & sel_in);
    assign ack_hit   = |(mem_pause_ack & sel_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bank_q        <= '0;
            cmd_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_err       <= 1'b0;
            mem_rst       <= '1;
            mem_pause_req <= '1;
            bank_on       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        bank_q    <= cmd_bank;
                        cmd_ready <= 1'b0;
                        cnt       <= '0;
                        if (!cmd_legal) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            state     <= RESP;
                        end else if (cmd_on == cur_on) begin
                            // Bank already in the requested state.
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            state     <= RESP;
                        end else if (cmd_on) begin
                            mem_rst <= mem_rst | sel_in;
                            state   <= RST_HOLD;
                        end else begin
                            mem_pause_req <= mem_pause_req | sel_in;
                            state         <= PAUSE;
                        end
                    end
                end

                RST_HOLD: begin
                    // cnt was cleared on acceptance, so the bank sees exactly
                    // RST_CYCLES cycles of reset while in this state.
                    if (cnt == CNT_RST_LAST) begin
                        mem_rst <= mem_rst & ~sel_q;
                        state   <= RST_REL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RST_REL: begin
                    mem_pause_req <= mem_pause_req & ~sel_q;
                    cnt           <= '0;
                    state         <= RESUME;
                end

                RESUME: begin
                    if (!ack_hit) begin
                        bank_on   <= bank_on | sel_q;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        state     <= RESP;
                    end
`ifdef ADAM_MEM_PWR_SEQ_TIMEOUT_EN
                    else if (cnt == CNT_TMO) begin
                        // Bank never left pause: put it back fully off.
                        mem_pause_req <= mem_pause_req | sel_q;
                        mem_rst       <= mem_rst | sel_q;
                        bank_on       <= bank_on & ~sel_q;
                        rsp_valid     <= 1'b1;
                        rsp_err       <= 1'b1;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end

                PAUSE: begin
                    if (ack_hit) begin
                        mem_rst <= mem_rst | sel_q;
                        bank_on <= bank_on & ~sel_q;
                        state   <= RST_SET;
                    end
`ifdef ADAM_MEM_PWR_SEQ_TIMEOUT_EN
                    else if (cnt == CNT_TMO) begin
                        // Pause never acknowledged: force the bank off anyway.
                        mem_rst   <= mem_rst | sel_q;
                        bank_on   <= bank_on & ~sel_q;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end

                RST_SET: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    state     <= RESP;
                end

                RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end

                default: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adam_mem_pwr_seq.sv
// Purpose  : directed, table-driven bench for adam_mem_pwr_seq (NO_MEMS=3, RST_CYCLES=4, ACK_TIMEOUT=10).
// Latency  : cycle numbers below count from the acceptance edge T; cycle n is sampled just after edge T+n-1.
// Backpress: commands are only presented while cmd_ready is high; the ack model follows pause_req with a delay.
module tb_adam_mem_pwr_seq;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_bank;
    logic       cmd_on;
    logic       rsp_valid;
    logic       rsp_err;
    logic [2:0] mem_rst;
    logic [2:0] mem_pause_req;
    logic [2:0] mem_pause_ack;
    logic [2:0] bank_on;

    int total = 0;
    int bad   = 0;

    // Ack model controls
    int   ack_dly;
    logic ack_force;
    logic ack_fval;
    int   acnt [3];

    adam_mem_pwr_seq #(
        .NO_MEMS    (3),
        .RST_CYCLES (4),
        .ACK_TIMEOUT(10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_bank     (cmd_bank),
        .cmd_on       (cmd_on),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .mem_rst      (mem_rst),
        .mem_pause_req(mem_pause_req),
        .mem_pause_ack(mem_pause_ack),
        .bank_on      (bank_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank model: ack copies pause_req ack_dly cycles after req changes,
    // or is pinned to ack_fval while ack_force is set.
    always @(posedge clk) begin
        for (int b = 0; b < 3; b++) begin
            if (rst) begin
                mem_pause_ack[b] <= 1'b1;
                acnt[b]          <= 0;
            end else if (ack_force) begin
                mem_pause_ack[b] <= ack_fval;
                acnt[b]          <= 0;
            end else if (mem_pause_ack[b] != mem_pause_req[b]) begin
                if (acnt[b] >= ack_dly - 1) begin
                    mem_pause_ack[b] <= mem_pause_req[b];
                    acnt[b]          <= 0;
                end else begin
                    acnt[b] <= acnt[b] + 1;
                end
            end else begin
                acnt[b] <= 0;
            end
        end
    end

    typedef struct {
        logic [1:0] bank;
        logic       on;
        int         dly;
        logic       frc;
        logic       fval;
        int         e_rsp;    // cycle of rsp_valid
        int         e_rst;    // first cycle mem_rst[bank] changes (0 = never)
        int         e_req;    // first cycle mem_pause_req[bank] changes (0 = never)
        logic       e_err;
        logic [2:0] e_mrst;   // full vectors at the rsp_valid cycle
        logic [2:0] e_preq;
        logic [2:0] e_on;
    } vec_t;

    localparam int NV     = 9;
    localparam int BUDGET = 60;
    vec_t tbl [NV];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic apply(input int id, input vec_t v);
        logic [2:0] pre_rst, pre_req, mask;
        int rsp_at, rst_at, req_at;
        logic err;
        logic [2:0] s_rst, s_req, s_on;
        ack_dly   = v.dly;
        ack_force = v.frc;
        ack_fval  = v.fval;
        pre_rst   = mem_rst;
        pre_req   = mem_pause_req;
        mask      = (v.bank < 2'd3) ? (3'b001 << v.bank) : 3'b000;
        rsp_at = 0; rst_at = 0; req_at = 0; err = 1'b0;
        s_rst = '0; s_req = '0; s_on = '0;
        chk($sformatf("r%0d_ready_pre", id), int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_bank  = v.bank;
        cmd_on    = v.on;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk($sformatf("r%0d_ready_busy", id), int'(cmd_ready), 0);
        for (int k = 1; k <= BUDGET; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            if (rst_at == 0 && ((mem_rst ^ pre_rst) & mask) != 3'b000) rst_at = k;
            if (req_at == 0 && ((mem_pause_req ^ pre_req) & mask) != 3'b000) req_at = k;
            if (rsp_valid) begin
                rsp_at = k;
                err    = rsp_err;
                s_rst  = mem_rst;
                s_req  = mem_pause_req;
                s_on   = bank_on;
                break;
            end
        end
        chk($sformatf("r%0d_rsp_cycle", id), rsp_at, v.e_rsp);
        chk($sformatf("r%0d_rsp_err", id), int'(err), int'(v.e_err));
        chk($sformatf("r%0d_rst_cycle", id), rst_at, v.e_rst);
        chk($sformatf("r%0d_req_cycle", id), req_at, v.e_req);
        chk($sformatf("r%0d_mem_rst", id), int'(s_rst), int'(v.e_mrst));
        chk($sformatf("r%0d_pause_req", id), int'(s_req), int'(v.e_preq));
        chk($sformatf("r%0d_bank_on", id), int'(s_on), int'(v.e_on));
        @(posedge clk);
        #1;
        chk($sformatf("r%0d_ready_back", id), int'(cmd_ready), 1);
        chk($sformatf("r%0d_rsp_one_cycle", id), int'(rsp_valid), 0);
        @(negedge clk);
        ack_force = 1'b0;
    endtask

    initial begin
        vec_t tv;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_bank  = 2'd0;
        cmd_on    = 1'b0;
        ack_dly   = 1;
        ack_force = 1'b0;
        ack_fval  = 1'b0;

        //            bank  on   dly frc fval rsp rst req err  mrst    preq    on
        tbl[0] = '{2'd1, 1'b1, 2, 1'b0, 1'b0, 9, 5, 6, 1'b0, 3'b101, 3'b101, 3'b010};
        tbl[1] = '{2'd1, 1'b0, 3, 1'b0, 1'b0, 6, 5, 1, 1'b0, 3'b111, 3'b111, 3'b000};
        tbl[2] = '{2'd0, 1'b1, 2, 1'b0, 1'b0, 9, 5, 6, 1'b0, 3'b110, 3'b110, 3'b001};
        tbl[3] = '{2'd0, 1'b1, 2, 1'b0, 1'b0, 1, 0, 0, 1'b0, 3'b110, 3'b110, 3'b001};
        tbl[4] = '{2'd3, 1'b1, 2, 1'b0, 1'b0, 1, 0, 0, 1'b1, 3'b110, 3'b110, 3'b001};
        tbl[5] = '{2'd2, 1'b0, 2, 1'b0, 1'b0, 1, 0, 0, 1'b0, 3'b110, 3'b110, 3'b001};
        tbl[6] = '{2'd2, 1'b1, 1, 1'b0, 1'b0, 8, 5, 6, 1'b0, 3'b010, 3'b010, 3'b101};
        tbl[7] = '{2'd0, 1'b0, 1, 1'b0, 1'b0, 4, 3, 1, 1'b0, 3'b011, 3'b011, 3'b100};
        tbl[8] = '{2'd0, 1'b1, 1, 1'b1, 1'b0, 7, 5, 6, 1'b0, 3'b010, 3'b010, 3'b101};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mem_rst", int'(mem_rst), 7);
        chk("reset_pause_req", int'(mem_pause_req), 7);
        chk("reset_bank_on", int'(bank_on), 0);
        chk("reset_cmd_ready", int'(cmd_ready), 1);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_err", int'(rsp_err), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) apply(i, tbl[i]);

        // Reset in the middle of RESUME: bank 1 waiting on a stuck-high ack,
        // banks 0 and 2 running.
        ack_force = 1'b1;
        ack_fval  = 1'b1;
        chk("mid_ready_pre", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_bank  = 2'd1;
        cmd_on    = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("mid_rst1_low", int'(mem_rst[1]), 0);
        chk("mid_req1_low", int'(mem_pause_req[1]), 0);
        chk("mid_no_rsp", int'(rsp_valid), 0);
        chk("mid_bank_on", int'(bank_on), 5);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid_mem_rst", int'(mem_rst), 7);
        chk("rstmid_pause_req", int'(mem_pause_req), 7);
        chk("rstmid_bank_on", int'(bank_on), 0);
        chk("rstmid_cmd_ready", int'(cmd_ready), 1);
        chk("rstmid_rsp_valid", int'(rsp_valid), 0);
        @(negedge clk);
        rst       = 1'b0;
        ack_force = 1'b0;
        @(negedge clk);
        @(negedge clk);

`ifdef ADAM_MEM_PWR_SEQ_TIMEOUT_EN
        // Power-on of bank 2 with ack stuck high times out at RST_CYCLES+13.
        tv = '{2'd2, 1'b1, 1, 1'b1, 1'b1, 17, 5, 6, 1'b1, 3'b111, 3'b111, 3'b000};
        apply(20, tv);
`endif

        // Sequencer still works after reset / timeout.
        tv = '{2'd0, 1'b1, 2, 1'b0, 1'b0, 9, 5, 6, 1'b0, 3'b110, 3'b110, 3'b001};
        apply(30, tv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
